// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL field
// positions, the run/stop state enum and the CTRL configuration payload.
package apb_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned OFFS_W     = 8;
    localparam int unsigned PRESCALE_W = 8;

    // Register byte offsets (PADDR[7:0])
    localparam logic [OFFS_W-1:0] OFFS_CTRL   = 8'h00;
    localparam logic [OFFS_W-1:0] OFFS_LOAD   = 8'h04;
    localparam logic [OFFS_W-1:0] OFFS_COUNT  = 8'h08;
    localparam logic [OFFS_W-1:0] OFFS_STATUS = 8'h0C;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_RELOAD_BIT   = 1;
    localparam int unsigned CTRL_IE_BIT       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 4;
    localparam int unsigned STATUS_TIF_BIT    = 0;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // Stored CTRL fields; EN lives in the core as the FSM state
    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  ie;
        logic                  reload;
    } ctrl_cfg_t;

    // Assemble the CTRL readback word; unused bits read as zero
    function automatic logic [DATA_W-1:0] ctrl_word(ctrl_cfg_t cfg, logic en);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_EN_BIT]                              = en;
        w[CTRL_RELOAD_BIT]                          = cfg.reload;
        w[CTRL_IE_BIT]                              = cfg.ie;
        w[CTRL_PRESCALE_LSB +: PRESCALE_W]          = cfg.prescale;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle for the timer slave.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : bridge -> timer
//   PRDATA                               : timer -> bridge
// No PREADY/PSLVERR: every access is zero-wait-state.
interface apb_timer_if;
    import apb_timer_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA
    );

endinterface

// File: rtl/apb_timer_core.sv
// timer_core: run/stop FSM, 8-bit prescaler and 32-bit down-counter.
//   clk, rst_n   : clock, async active-low reset
//   ctrl_wr      : CTRL write commits this edge; ctrl_en is its EN bit
//   count_wr     : COUNT write commits this edge with wdata
//   load, reload, prescale : current register configuration
//   running      : FSM is in RUN (reads back as CTRL.EN)
//   count        : current counter value
//   expire_c     : tick with count==0 on this edge (combinational)
module timer_core
    import apb_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_wr,
    input  logic                  ctrl_en,
    input  logic                  count_wr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     load,
    input  logic                  reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  running,
    output logic [DATA_W-1:0]     count,
    output logic                  expire_c
);

    timer_state_e          state_q, state_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick;

    // State, counter and prescaler registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    // Next-state: APB writes take priority over the tick's effects
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        tick     = 1'b0;
        expire_c = 1'b0;

        unique case (state_q)
            ST_STOP: begin
                if (ctrl_wr) begin
                    presc_d = '0;
                    if (ctrl_en) begin
                        state_d = ST_RUN;
                        count_d = load;
                    end
                end else if (count_wr) begin
                    count_d = wdata;
                end
            end

            ST_RUN: begin
                if (ctrl_wr) begin
                    // Any CTRL write restarts the prescaler and swallows the tick
                    presc_d = '0;
                    if (!ctrl_en) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    if (presc_q == prescale) begin
                        presc_d = '0;
                        tick    = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESCALE_W'(1);
                    end

                    if (count_wr) begin
                        count_d = wdata;
                    end else if (tick) begin
                        if (count_q != '0) begin
                            count_d = count_q - DATA_W'(1);
                        end else begin
                            expire_c = 1'b1;
                            if (reload) begin
                                count_d = load;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    assign running = (state_q == ST_RUN);
    assign count   = count_q;

endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB-mapped down-counting timer with prescaler and interrupt.
//   HCLK, HRESETn : clock, async active-low reset
//   bus           : APB slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA out)
//   IRQ           : level interrupt, STATUS.TIF & CTRL.IE, registered
// Map: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS; others read 0.
module apb_timer
    import apb_timer_pkg::*;
(
    input  logic         HCLK,
    input  logic         HRESETn,
    apb_timer_if.slave   bus,
    output logic         IRQ
);

    logic [OFFS_W-1:0] offs;
    logic              wr_c;
    logic              rd_setup_c;
    logic              ctrl_wr, load_wr, count_wr, status_wr;

    ctrl_cfg_t         cfg_q, cfg_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              tif_q, tif_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] rdata_c;

    logic              running;
    logic [DATA_W-1:0] count;
    logic              expire_c;

    logic              unused_addr;

    // Only the low address byte is decoded
    assign offs        = bus.PADDR[OFFS_W-1:0];
    assign unused_addr = ^bus.PADDR[ADDR_W-1:OFFS_W];

    assign wr_c       = bus.PSEL & bus.PENABLE & bus.PWRITE;
    assign rd_setup_c = bus.PSEL & ~bus.PENABLE & ~bus.PWRITE;

    assign ctrl_wr   = wr_c && (offs == OFFS_CTRL);
    assign load_wr   = wr_c && (offs == OFFS_LOAD);
    assign count_wr  = wr_c && (offs == OFFS_COUNT);
    assign status_wr = wr_c && (offs == OFFS_STATUS);

    timer_core u_core (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .ctrl_wr  (ctrl_wr),
        .ctrl_en  (bus.PWDATA[CTRL_EN_BIT]),
        .count_wr (count_wr),
        .wdata    (bus.PWDATA),
        .load     (load_q),
        .reload   (cfg_q.reload),
        .prescale (cfg_q.prescale),
        .running  (running),
        .count    (count),
        .expire_c (expire_c)
    );

    // Register next-state; expiry set wins over a same-edge TIF clear
    always_comb begin
        cfg_d  = cfg_q;
        load_d = load_q;
        tif_d  = tif_q;

        if (ctrl_wr) begin
            cfg_d.prescale = bus.PWDATA[CTRL_PRESCALE_LSB +: PRESCALE_W];
            cfg_d.ie       = bus.PWDATA[CTRL_IE_BIT];
            cfg_d.reload   = bus.PWDATA[CTRL_RELOAD_BIT];
        end
        if (load_wr) begin
            load_d = bus.PWDATA;
        end
        if (status_wr && bus.PWDATA[STATUS_TIF_BIT]) begin
            tif_d = 1'b0;
        end
        if (expire_c) begin
            tif_d = 1'b1;
        end

        // IRQ flop tracks the next TIF/IE so it rises on the expiry edge
        irq_d = tif_d & cfg_d.ie;
    end

    // Read mux, captured into PRDATA on the read setup edge
    always_comb begin
        rdata_c = '0;
        unique case (offs)
            OFFS_CTRL:   rdata_c = ctrl_word(cfg_q, running);
            OFFS_LOAD:   rdata_c = load_q;
            OFFS_COUNT:  rdata_c = count;
            OFFS_STATUS: rdata_c = DATA_W'(tif_q);
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cfg_q    <= '0;
            load_q   <= '0;
            tif_q    <= 1'b0;
            irq_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            load_q <= load_d;
            tif_q  <= tif_d;
            irq_q  <= irq_d;
            if (rd_setup_c) begin
                prdata_q <= rdata_c;
            end
        end
    end

    assign bus.PRDATA = prdata_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Testbench for apb_timer: directed APB sequences with hand-computed
// expectations. Reads push the expected PRDATA/IRQ into a scoreboard;
// a monitor pops and compares during each read access phase.
module tb_apb_timer;
    import apb_timer_pkg::*;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    logic IRQ;

    apb_timer_if bus ();

    apb_timer dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .IRQ     (IRQ)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [31:0] A_CTRL   = 32'(OFFS_CTRL);
    localparam logic [31:0] A_LOAD   = 32'(OFFS_LOAD);
    localparam logic [31:0] A_COUNT  = 32'(OFFS_COUNT);
    localparam logic [31:0] A_STATUS = 32'(OFFS_STATUS);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: PRDATA is valid through the read access phase
    always @(negedge HCLK) begin
        if (HRESETn && bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got 0x%08h, want no access", bus.PRDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".prdata"}, bus.PRDATA, e.data);
                check({e.name, ".irq"}, 32'(IRQ), 32'(e.irq));
            end
        end
    end

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
    endtask

    // Tasks start and end 1 time unit after a rising edge
    task automatic idle(int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Setup on the first edge, commit on the second
    task automatic apb_write(logic [31:0] addr, logic [31:0] data);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        @(posedge HCLK);
        #1 bus.PENABLE = 1'b1;
        @(posedge HCLK);
        #1 bus_idle();
    endtask

    // PRDATA reflects registers as of the edge before the setup edge;
    // IRQ is sampled after the setup edge
    task automatic apb_read(string name, logic [31:0] addr,
                            logic [31:0] exp_data, logic exp_irq);
        exp_t e;
        e.name = name;
        e.data = exp_data;
        e.irq  = exp_irq;
        sb.push_back(e);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = addr;
        @(posedge HCLK);
        #1 bus.PENABLE = 1'b1;
        @(posedge HCLK);
        #1 bus_idle();
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        HRESETn = 1'b0;
        #12;
        check("reset.prdata", bus.PRDATA, 32'h0);
        check("reset.irq", 32'(IRQ), 32'h0);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Cold register values
        apb_read("cold.ctrl",   A_CTRL,   32'h0, 1'b0);
        apb_read("cold.load",   A_LOAD,   32'h0, 1'b0);
        apb_read("cold.count",  A_COUNT,  32'h0, 1'b0);
        apb_read("cold.status", A_STATUS, 32'h0, 1'b0);

        // Auto-reload, PRESCALE=0: expiry every 4 edges from E0
        apb_write(A_LOAD, 32'd3);
        apb_write(A_CTRL, 32'h7);                           // E0
        idle(2);                                            // E1,E2
        apb_read("ar.tif_pre",  A_STATUS, 32'h0, 1'b0);     // setup E3
        apb_read("ar.reload",   A_COUNT,  32'd3, 1'b1);     // setup E5
        apb_write(A_STATUS, 32'h1);                         // commit E8 = expiry
        apb_read("ar.set_wins", A_STATUS, 32'h1, 1'b1);     // setup E9
        idle(1);                                            // E11
        apb_write(A_STATUS, 32'h1);                         // commit E13
        apb_read("ar.cleared",  A_STATUS, 32'h0, 1'b0);     // setup E14
        apb_read("ar.period",   A_STATUS, 32'h0, 1'b1);     // setup E16, expiry E16
        apb_write(A_CTRL, 32'h0);
        apb_read("ar.stopped",  A_CTRL,   32'h0, 1'b0);
        apb_write(A_STATUS, 32'h1);

        // Prescaled one-shot: LOAD=2, PRESCALE=2 -> expiry at E9
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h021);                         // E0
        idle(5);                                            // E1..E5
        apb_read("os.running",  A_CTRL,   32'h021, 1'b0);   // setup E6
        apb_read("os.tif_pre",  A_STATUS, 32'h0,   1'b0);   // setup E8
        apb_read("os.tif",      A_STATUS, 32'h1,   1'b0);   // setup E10
        apb_read("os.en_clr",   A_CTRL,   32'h020, 1'b0);
        apb_read("os.count0",   A_COUNT,  32'h0,   1'b0);
        idle(5);
        apb_read("os.hold0",    A_COUNT,  32'h0,   1'b0);

        // Readback and unmapped offsets
        apb_write(A_LOAD, 32'hDEADBEEF);
        apb_read("rb.load",     A_LOAD,        32'hDEADBEEF, 1'b0);
        apb_read("rb.load_hi",  32'hFFFF_FF04, 32'hDEADBEEF, 1'b0);
        apb_write(32'h10, 32'h12345678);
        apb_read("rb.unmap10",  32'h10, 32'h0, 1'b0);
        apb_read("rb.unmap01",  32'h01, 32'h0, 1'b0);
        apb_read("rb.load_kept", A_LOAD, 32'hDEADBEEF, 1'b0);

        // Full-scale count-down from 0xFFFFFFFF
        apb_write(A_LOAD, 32'hFFFF_FFFF);
        apb_write(A_CTRL, 32'h1);                           // E0
        apb_read("fs.start",    A_COUNT, 32'hFFFF_FFFF, 1'b0);  // setup E1
        apb_read("fs.down",     A_COUNT, 32'hFFFF_FFFD, 1'b0);  // setup E3
        apb_write(A_CTRL, 32'h0);

        // COUNT write on a tick edge (PRESCALE=3: ticks at E4, E8, E12)
        apb_write(A_LOAD, 32'h100);
        apb_write(A_CTRL, 32'h031);                         // E0
        idle(6);                                            // E1..E6
        apb_write(A_COUNT, 32'h10);                         // commit E8
        apb_read("ov.written",  A_COUNT, 32'h10, 1'b0);     // setup E9
        apb_read("ov.held",     A_COUNT, 32'h10, 1'b0);     // setup E11
        apb_read("ov.next",     A_COUNT, 32'h0F, 1'b0);     // setup E13
        apb_write(A_CTRL, 32'h0);

        // Reset mid-count (COUNT=5, TIF=1, IE=1) during a write setup
        apb_write(A_LOAD, 32'd5);
        apb_write(A_CTRL, 32'h005);
        bus.PSEL   = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = A_LOAD;
        bus.PWDATA = 32'h55;
        #1 HRESETn = 1'b0;
        #1;
        check("rst.prdata", bus.PRDATA, 32'h0);
        check("rst.irq", 32'(IRQ), 32'h0);
        @(posedge HCLK);
        #1 bus.PENABLE = 1'b1;
        @(posedge HCLK);
        #1 bus_idle();
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        apb_read("rst.ctrl",   A_CTRL,   32'h0, 1'b0);
        apb_read("rst.load",   A_LOAD,   32'h0, 1'b0);
        apb_read("rst.count",  A_COUNT,  32'h0, 1'b0);
        apb_read("rst.status", A_STATUS, 32'h0, 1'b0);
        idle(8);
        apb_read("rst.no_tick",  A_COUNT,  32'h0, 1'b0);
        apb_read("rst.no_tif",   A_STATUS, 32'h0, 1'b0);

        // First use after reset behaves as from cold: LOAD=1 one-shot, IE
        apb_write(A_LOAD, 32'd1);
        apb_write(A_CTRL, 32'h005);                         // E0, expiry E2
        apb_read("cold2.pre",  A_STATUS, 32'h0,   1'b0);    // setup E1
        apb_read("cold2.tif",  A_STATUS, 32'h1,   1'b1);    // setup E3
        apb_read("cold2.ctrl", A_CTRL,   32'h004, 1'b1);

        idle(2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        summary();
        $finish;
    end

endmodule
